// File: rtl/crono_pkg.sv
// Shared types and constants for the crono_regresivo countdown timer.
// Holds FSM state encodings, BCD limits and the preset clamp helper.
package crono_pkg;

  localparam int BCD_W = 8;

  localparam logic [BCD_W-1:0] BCD_LIM_MS = 8'h59;
  localparam logic [BCD_W-1:0] BCD_ZERO   = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSA = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } crono_state_t;

  // Bad digits or over-limit values saturate to the limit; BCD orders like binary.
  function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] val,
                                                 input logic [BCD_W-1:0] lim);
    if ((val[7:4] > 4'd9) || (val[3:0] > 4'd9) || (val > lim))
      return lim;
    return val;
  endfunction

endpackage

// File: rtl/bcd_dec_campo.sv
// Two-digit BCD down counter with load; WRAP=0 saturates at 00 instead of
// wrapping to limite. borrow_out flags an enabled decrement from 00.
module bcd_dec_campo
  import crono_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             en,
  input  logic [BCD_W-1:0] limite,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] valor,
  output logic             borrow_out
);

  logic [BCD_W-1:0] r_valor;
  logic [BCD_W-1:0] w_dec;

  always_comb begin
    w_dec = r_valor;
    if (r_valor[3:0] == 4'd0)
      w_dec = {r_valor[7:4] - 4'd1, 4'd9};
    else
      w_dec = {r_valor[7:4], r_valor[3:0] - 4'd1};
  end

  always_ff @(posedge CLK) begin
    if (reset)
      r_valor <= BCD_ZERO;
    else if (load)
      r_valor <= load_val;
    else if (en) begin
      if (r_valor == BCD_ZERO)
        r_valor <= WRAP ? limite : BCD_ZERO;
      else
        r_valor <= w_dec;
    end
  end

  assign valor      = r_valor;
  assign borrow_out = en && (r_valor == BCD_ZERO);

endmodule

// File: rtl/crono_regresivo.sv
// HH:MM:SS BCD countdown timer raising fin_crono at zero until acknowledged.
// Define CRONO_AUTORECARGA_EN to reload the preset at expiry and keep running.
module crono_regresivo
  import crono_pkg::*;
#(
  parameter logic [7:0] MAX_HH = 8'h23
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic [7:0] ini_hh,
  input  logic [7:0] ini_mm,
  input  logic [7:0] ini_ss,
  input  logic       start,
  input  logic       stop,
  input  logic       ack,
  output logic [7:0] cnt_hh,
  output logic [7:0] cnt_mm,
  output logic [7:0] cnt_ss,
  output logic       running,
  output logic       fin_crono
);

  crono_state_t r_state;
  logic         r_running;
  logic         r_fin;
  logic [7:0]   r_pre_hh, r_pre_mm, r_pre_ss;

  logic [7:0] w_cl_hh, w_cl_mm, w_cl_ss;
  logic [7:0] w_ld_hh, w_ld_mm, w_ld_ss;
  logic [7:0] w_hh, w_mm, w_ss;
  logic       w_ini_zero, w_cnt_zero, w_cnt_uno;
  logic       w_ack_fin, w_load_ok, w_stop_ok, w_start_ok;
  logic       w_tick_en, w_expira, w_recarga, w_cnt_load;
  logic       w_bor_ss, w_bor_mm, w_bor_hh;

  assign w_cl_hh = clamp_bcd(ini_hh, MAX_HH);
  assign w_cl_mm = clamp_bcd(ini_mm, BCD_LIM_MS);
  assign w_cl_ss = clamp_bcd(ini_ss, BCD_LIM_MS);

  assign w_ini_zero = ({w_cl_hh, w_cl_mm, w_cl_ss} == 24'h000000);
  assign w_cnt_zero = ({w_hh, w_mm, w_ss} == 24'h000000);
  assign w_cnt_uno  = ({w_hh, w_mm, w_ss} == 24'h000001);

`ifdef CRONO_AUTORECARGA_EN
  assign w_ack_fin = 1'b0;
`else
  assign w_ack_fin = ack && (r_state == FIN);
`endif

  assign w_load_ok  = load && (r_state != RUN) && !w_ack_fin;
  assign w_stop_ok  = stop && (r_state == RUN);
  assign w_start_ok = start && (r_state == PAUSA) && !w_cnt_zero;
  // stop outranks a same-cycle tick, freezing the count
  assign w_tick_en  = tick_1hz && (r_state == RUN) && !stop;
  assign w_expira   = w_tick_en && w_cnt_uno;

`ifdef CRONO_AUTORECARGA_EN
  assign w_recarga = w_expira;
`else
  assign w_recarga = 1'b0;
`endif

  assign w_cnt_load = w_load_ok || w_recarga;
  assign w_ld_hh    = w_load_ok ? w_cl_hh : r_pre_hh;
  assign w_ld_mm    = w_load_ok ? w_cl_mm : r_pre_mm;
  assign w_ld_ss    = w_load_ok ? w_cl_ss : r_pre_ss;

  bcd_dec_campo #(.WRAP(1'b1)) u_ss (
    .CLK(CLK), .reset(reset), .en(w_tick_en), .limite(BCD_LIM_MS),
    .load(w_cnt_load), .load_val(w_ld_ss), .valor(w_ss), .borrow_out(w_bor_ss)
  );

  bcd_dec_campo #(.WRAP(1'b1)) u_mm (
    .CLK(CLK), .reset(reset), .en(w_bor_ss), .limite(BCD_LIM_MS),
    .load(w_cnt_load), .load_val(w_ld_mm), .valor(w_mm), .borrow_out(w_bor_mm)
  );

  bcd_dec_campo #(.WRAP(1'b0)) u_hh (
    .CLK(CLK), .reset(reset), .en(w_bor_mm), .limite(MAX_HH),
    .load(w_cnt_load), .load_val(w_ld_hh), .valor(w_hh), .borrow_out(w_bor_hh)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_pre_hh <= BCD_ZERO;
      r_pre_mm <= BCD_ZERO;
      r_pre_ss <= BCD_ZERO;
    end else if (w_load_ok) begin
      r_pre_hh <= w_cl_hh;
      r_pre_mm <= w_cl_mm;
      r_pre_ss <= w_cl_ss;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_fin     <= 1'b0;
    end else begin
`ifdef CRONO_AUTORECARGA_EN
      if (ack)
        r_fin <= 1'b0;
      else if (w_expira)
        r_fin <= 1'b1;
      if (w_load_ok) begin
        r_state   <= w_ini_zero ? IDLE : PAUSA;
        r_running <= 1'b0;
      end else if (w_stop_ok) begin
        r_state   <= PAUSA;
        r_running <= 1'b0;
      end else if (w_start_ok) begin
        r_state   <= RUN;
        r_running <= 1'b1;
      end
`else
      if (w_ack_fin) begin
        r_state   <= IDLE;
        r_running <= 1'b0;
        r_fin     <= 1'b0;
      end else if (w_load_ok) begin
        r_state   <= w_ini_zero ? IDLE : PAUSA;
        r_running <= 1'b0;
        r_fin     <= 1'b0;
      end else if (w_stop_ok) begin
        r_state   <= PAUSA;
        r_running <= 1'b0;
      end else if (w_start_ok) begin
        r_state   <= RUN;
        r_running <= 1'b1;
      end else if (w_expira) begin
        r_state   <= FIN;
        r_running <= 1'b0;
        r_fin     <= 1'b1;
      end
`endif
    end
  end

  assign cnt_hh    = w_hh;
  assign cnt_mm    = w_mm;
  assign cnt_ss    = w_ss;
  assign running   = r_running;
  assign fin_crono = r_fin;

endmodule

// File: tb/tb_crono_regresivo.sv
// Directed self-checking bench for crono_regresivo; follows CRONO_AUTORECARGA_EN
// to select the expiry behaviour under test.
module tb_crono_regresivo;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, ack = 1'b0;
  logic [7:0] ini_hh = 8'h00, ini_mm = 8'h00, ini_ss = 8'h00;
  logic [7:0] cnt_hh, cnt_mm, cnt_ss;
  logic       running, fin_crono;

  int checks = 0;
  int errors = 0;

  crono_regresivo #(.MAX_HH(8'h23)) dut (
    .CLK(CLK), .reset(reset), .tick_1hz(tick_1hz), .load(load),
    .ini_hh(ini_hh), .ini_mm(ini_mm), .ini_ss(ini_ss),
    .start(start), .stop(stop), .ack(ack),
    .cnt_hh(cnt_hh), .cnt_mm(cnt_mm), .cnt_ss(cnt_ss),
    .running(running), .fin_crono(fin_crono)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // one cycle of the given command pulses, then all released
  task automatic cmd(input logic l, input logic st, input logic sp,
                     input logic tk, input logic ak);
    load = l; start = st; stop = sp; tick_1hz = tk; ack = ak;
    step();
    load = 1'b0; start = 1'b0; stop = 1'b0; tick_1hz = 1'b0; ack = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    ini_hh = h; ini_mm = m; ini_ss = s;
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [23:0] cnt,
                        input logic run, input logic fin);
    chk({tag, "_cnt"}, {cnt_hh, cnt_mm, cnt_ss}, cnt);
    chk({tag, "_run"}, {23'd0, running}, {23'd0, run});
    chk({tag, "_fin"}, {23'd0, fin_crono}, {23'd0, fin});
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    chk_st("reset", 24'h000000, 1'b0, 1'b0);

    // clamp of illegal presets
    do_load(8'h7A, 8'h75, 8'h99);
    chk_st("clamp", 24'h235959, 1'b0, 1'b0);
    do_load(8'h00, 8'h00, 8'h00);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_st("zero_start", 24'h000000, 1'b0, 1'b0);

`ifdef CRONO_AUTORECARGA_EN
    do_load(8'h00, 8'h00, 8'h02);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_st("ar_start", 24'h000002, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("ar_t1", 24'h000001, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("ar_reload", 24'h000002, 1'b1, 1'b1);
    step();
    chk_st("ar_sticky", 24'h000002, 1'b1, 1'b1);
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_st("ar_ack", 24'h000002, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("ar_t3", 24'h000001, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_st("ar_stop", 24'h000001, 1'b0, 1'b0);
`else
    // basic 3 second run to expiry
    do_load(8'h00, 8'h00, 8'h03);
    chk_st("ld3", 24'h000003, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_st("start3", 24'h000003, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("t1", 24'h000002, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("t2", 24'h000001, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("t3_fin", 24'h000000, 1'b0, 1'b1);
    cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_st("fin_hold", 24'h000000, 1'b0, 1'b1);
    cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_st("ack", 24'h000000, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_st("idle_start", 24'h000000, 1'b0, 1'b0);

    // double borrow
    do_load(8'h01, 8'h00, 8'h00);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("borrow2", 24'h005959, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("borrow_next", 24'h005958, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_st("stop_a", 24'h005958, 1'b0, 1'b0);

    // stop colliding with a tick, then resume to expiry
    do_load(8'h00, 8'h00, 8'h05);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk_st("stop_tick", 24'h000003, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("pausa_tick", 24'h000003, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("resume_fin", 24'h000000, 1'b0, 1'b1);

    // ack outranks load in FIN
    ini_hh = 8'h00; ini_mm = 8'h00; ini_ss = 8'h07;
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_st("ack_over_load", 24'h000000, 1'b0, 1'b0);

    // load in FIN clears the flag and arms a new count
    do_load(8'h00, 8'h00, 8'h01);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("fin_again", 24'h000000, 1'b0, 1'b1);
    do_load(8'h00, 8'h00, 8'h04);
    chk_st("load_in_fin", 24'h000004, 1'b0, 1'b0);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_st("run4", 24'h000004, 1'b1, 1'b0);

    // load ignored while running, then reset mid-count
    do_load(8'h00, 8'h00, 8'h02);
    cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_load(8'h00, 8'h00, 8'h02);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_load(8'h00, 8'h00, 8'h09);
    chk_st("load_in_run", 24'h000002, 1'b1, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_st("reset_run", 24'h000000, 1'b0, 1'b0);

    // reset out of FIN
    do_load(8'h00, 8'h00, 8'h01);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_st("fin_pre_reset", 24'h000000, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_st("reset_fin", 24'h000000, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crono_regresivo.md
Name: crono_regresivo

Overview:
- Countdown timer (HH:MM:SS, BCD) that produces the `fin_crono` expiry flag.
- The alarm/blink block consumes `fin_crono`.
- Counts down one second per `tick_1hz` pulse from a user-loaded preset.
- Raises `fin_crono` at 00:00:00 and holds it until acknowledged.
- Sits between the user-input/edit logic (preset, start/stop, ack) and the alarm block.

Parameters:
- MAX_HH, 8'h23: highest legal BCD hour value; the hours preset clamps to this.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick_1hz  input  1  one-CLK-wide pulse, once per second.
- load  input  1  pulse: capture preset from `ini_hh`/`ini_mm`/`ini_ss`.
- ini_hh  input  8  preset hours, BCD.
- ini_mm  input  8  preset minutes, BCD.
- ini_ss  input  8  preset seconds, BCD.
- start  input  1  pulse: begin/resume counting.
- stop  input  1  pulse: pause counting.
- ack  input  1  pulse: acknowledge expiry, clear `fin_crono`.
- cnt_hh  output  8  current hours, BCD.
- cnt_mm  output  8  current minutes, BCD.
- cnt_ss  output  8  current seconds, BCD.
- running  output  1  high while in RUN.
- fin_crono  output  1  expiry flag to the alarm block.

Behaviour:
- Clock and reset: one clock `CLK`; reset is synchronous and active-high, named `reset`.
- Reset values:
  - state = IDLE.
  - Preset and count registers = 00:00:00.
  - `running` = 0, `fin_crono` = 0.
- All outputs are registered.
- States: IDLE, PAUSA, RUN, FIN.
- Command priority in the same cycle: `ack` > `load` > `stop` > `start` > `tick_1hz`.
- `load` (accepted in IDLE, PAUSA, FIN; ignored in RUN):
  - Clamp each field: any BCD digit >9, or value above its limit (ss/mm 8'h59, hh MAX_HH), is replaced by the limit.
  - Write the clamped value to both the preset and count registers.
  - Next state: PAUSA if nonzero, IDLE if 00:00:00.
  - In FIN, `load` also clears `fin_crono`.
- `start`:
  - PAUSA with nonzero count -> RUN.
  - Ignored in every other state, and when count = 0.
- `stop`: RUN -> PAUSA; count frozen; any `tick_1hz` in that cycle is ignored.
- `tick_1hz` in RUN:
  - ss decrements in BCD; 00 wraps to 59 with a borrow into mm.
  - mm decrements the same way, borrowing into hh; hh decrements without wrap.
  - Updated count is visible the cycle after the tick.
- Expiry: a tick that moves the count from 00:00:01 to 00:00:00 moves state RUN -> FIN and sets `fin_crono` on the same edge.
- Count never underflows; ticks outside RUN are ignored.
- FIN:
  - Count holds 00:00:00; `fin_crono` = 1.
  - `ack` -> IDLE, `fin_crono` = 0 next cycle.
  - `start`, `stop` and ticks are ignored.
- `ack` outside FIN: no effect.
- `running` = 1 exactly while state = RUN.
- `reset` in any state, including mid-count or in FIN, returns to the reset values on the next edge.

Optional Feature:
- Macro: CRONO_AUTORECARGA_EN.
- Defined:
  - At expiry the count reloads from the preset on the same edge and state stays RUN.
  - `fin_crono` is set and stays sticky; `ack` clears `fin_crono` only, without changing state.
  - `stop` still pauses; FIN is unreachable.
- Undefined: behaviour as above (FIN state, count held at zero).

Decomposition:
- Shared package/header crono_pkg:
  - State encodings: IDLE=2'd0, PAUSA=2'd1, RUN=2'd2, FIN=2'd3.
  - BCD limit constants: 8'h59, 8'h00.
  - 8-bit BCD field width.
- Sub-module bcd_dec_campo: two-digit BCD down counter.
  - Inputs: `en`/borrow-in, `limite`, `load`, `load_val`.
  - Outputs: `valor`, `borrow_out`.
  - `borrow_out` is asserted when `valor` = 00 and `en` is high.
  - Three instances chained ss -> mm -> hh; the hh instance has wrap disabled.
- Top handles the FSM, input clamping and zero detection.

Test Plan:
- Load 00:00:03, `start`, 3 ticks:
  - Counts 02, 01, 00.
  - `fin_crono` rises the cycle after the 3rd tick; `running` falls.
  - `ack` -> `fin_crono` = 0, state IDLE.
- Load 01:00:00, `start`, 1 tick -> 00:59:59 (double borrow); further ticks -> 00:59:58.
- Load 00:00:05, `start`, 2 ticks, `stop` together with a tick -> count holds 00:00:03, `running` = 0; `start`, 3 ticks -> `fin_crono` = 1.
- Load ini 8'h7A:8'h75:8'h99 -> count reads 23:59:59; load 00:00:00 then `start` -> remains IDLE, `running` = 0.
- In RUN at 00:00:02, assert `load` and `reset` in separate runs:
  - `load` ignored, count unchanged.
  - `reset` -> 00:00:00, IDLE, `fin_crono` = 0.
- CRONO_AUTORECARGA_EN defined, preset 00:00:02, `start`, 2 ticks:
  - `fin_crono` = 1, count = 00:00:02, `running` = 1.
  - `ack` clears `fin_crono`; next tick -> 00:00:01.
